// File: rtl/dvi_pkg.sv
// Shared DVI output-path definitions: TMDS word constants and the phase
// sequencer state encoding.
package dvi_pkg;

    localparam int TMDS_BITS = 10;

    localparam logic [TMDS_BITS-1:0] TMDS_CTRL_00     = 10'b1101010100;
    localparam logic [TMDS_BITS-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/tmds_shift10.sv
// 10-bit load/shift register for one TMDS lane: parallel load, LSB-first
// shift-out with zero fill, synchronous clear.
module tmds_shift10
    import dvi_pkg::*;
(
    input  logic                 clk_tmds,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [TMDS_BITS-1:0] din,
    output logic                 ser
);

    logic [TMDS_BITS-1:0] sr_q, sr_d;

    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Clear wins over load so a drop to IDLE flushes a word mid-flight.
    always_comb begin
        sr_d = {1'b0, sr_q[TMDS_BITS-1:1]};
        if (clr) begin
            sr_d = '0;
        end else if (load) begin
            sr_d = din;
        end
    end

    assign ser = sr_q[0];

endmodule

// File: rtl/tmds_phase_sequencer.sv
// Recovers pixel phase from pix_toggle in the TMDS bit-clock domain, runs the
// IDLE/SEARCH/LOCKED supervisor and schedules word loads into four serializers.
module tmds_phase_sequencer
    import dvi_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int LOAD_OFFSET = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_tmds,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pix_toggle,
    input  logic [TMDS_BITS-1:0] word_red,
    input  logic [TMDS_BITS-1:0] word_green,
    input  logic [TMDS_BITS-1:0] word_blue,
    output logic                 ser_red,
    output logic                 ser_green,
    output logic                 ser_blue,
    output logic                 ser_clk,
    output logic                 load,
    output logic                 locked,
    output logic [7:0]           slip_count,
    output seq_state_t           dbg_state
);

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);
    localparam logic [3:0] LOAD_SLOT   = 4'(LOAD_OFFSET);
    localparam logic [3:0] LAST_SLOT   = 4'(TMDS_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    seq_state_t             state_q, state_d;
    logic [3:0]             slot_q, slot_d;
    logic [7:0]             match_q, match_d;
    logic [7:0]             slip_count_q, slip_count_d;
    logic                   load_q, load_d;
    logic                   locked_q, locked_d;

    logic                   pix_edge;
    logic                   on_time;
    logic                   slip;
    logic                   sr_clr;
    logic [TMDS_BITS-1:0]   din_red, din_green, din_blue;

    // State register process: every flop of the block lives here.
    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            slot_q       <= '0;
            match_q      <= '0;
            slip_count_q <= '0;
            load_q       <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            slot_q       <= slot_d;
            match_q      <= match_d;
            slip_count_q <= slip_count_d;
            load_q       <= load_d;
            locked_q     <= locked_d;
        end
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pix_toggle};
        prev_d   = sync_q[SYNC_STAGES-1];
        pix_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
        on_time  = pix_edge && (slot_q == LAST_SLOT);
    end

    // Next-state process: lock supervision, slot counter and slip accounting.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        slip    = 1'b0;
        unique case (state_q)
            IDLE: begin
                match_d = '0;
                if (enable) state_d = SEARCH;
            end
            SEARCH: begin
                if (on_time) begin
                    match_d = match_q + 8'd1;
                    if (match_q + 8'd1 >= LOCK_TARGET) begin
                        state_d = LOCKED;
                        match_d = '0;
                    end
                end else if (pix_edge) begin
                    match_d = '0;
                    slip    = 1'b1;
                end
            end
            LOCKED: begin
                match_d = '0;
                // An off-time edge and a missing edge both mean the phase moved.
                if ((pix_edge && !on_time) || (!pix_edge && slot_q == LAST_SLOT)) begin
                    state_d = SEARCH;
                    slip    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            match_d = '0;
            slip    = 1'b0;
        end

        if (state_q == IDLE || state_d == IDLE || pix_edge || slot_q == LAST_SLOT) begin
            slot_d = '0;
        end else begin
            slot_d = slot_q + 4'd1;
        end

        slip_count_d = slip_count_q;
        if (slip && slip_count_q != 8'hFF) begin
            slip_count_d = slip_count_q + 8'd1;
        end
    end

    // Output process: load/locked are decoded one cycle early so they leave
    // the block registered and line up with slot_q/state_q.
    always_comb begin
        load_d    = (state_d != IDLE) && (slot_d == LOAD_SLOT);
        locked_d  = (state_d == LOCKED);
        sr_clr    = (state_d == IDLE);
        din_red   = (state_q == LOCKED) ? word_red   : TMDS_CTRL_00;
        din_green = (state_q == LOCKED) ? word_green : TMDS_CTRL_00;
        din_blue  = (state_q == LOCKED) ? word_blue  : TMDS_CTRL_00;
    end

    tmds_shift10 u_shift_red (
        .clk_tmds (clk_tmds),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .load     (load_q),
        .din      (din_red),
        .ser      (ser_red)
    );

    tmds_shift10 u_shift_green (
        .clk_tmds (clk_tmds),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .load     (load_q),
        .din      (din_green),
        .ser      (ser_green)
    );

    tmds_shift10 u_shift_blue (
        .clk_tmds (clk_tmds),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .load     (load_q),
        .din      (din_blue),
        .ser      (ser_blue)
    );

    tmds_shift10 u_shift_clk (
        .clk_tmds (clk_tmds),
        .rst_n    (rst_n),
        .clr      (sr_clr),
        .load     (load_q),
        .din      (TMDS_CLK_PATTERN),
        .ser      (ser_clk)
    );

    assign load       = load_q;
    assign locked     = locked_q;
    assign slip_count = slip_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tmds_phase_sequencer.sv
// Directed bench for tmds_phase_sequencer: lock acquisition, serial data,
// slips, relock, saturation, enable drop and reset mid-word.
module tb_tmds_phase_sequencer;
    import dvi_pkg::*;

    logic       clk_tmds = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pix_toggle;
    logic [9:0] word_red, word_green, word_blue;
    logic       ser_red, ser_green, ser_blue, ser_clk;
    logic       load, locked;
    logic [7:0] slip_count;
    seq_state_t dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int kk;
    int ph;
    logic [9:0] ctrl_w;
    logic [9:0] clk_w;

    tmds_phase_sequencer #(
        .LOCK_COUNT  (16),
        .LOAD_OFFSET (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_tmds   (clk_tmds),
        .rst_n      (rst_n),
        .enable     (enable),
        .pix_toggle (pix_toggle),
        .word_red   (word_red),
        .word_green (word_green),
        .word_blue  (word_blue),
        .ser_red    (ser_red),
        .ser_green  (ser_green),
        .ser_blue   (ser_blue),
        .ser_clk    (ser_clk),
        .load       (load),
        .locked     (locked),
        .slip_count (slip_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk_tmds = ~clk_tmds;

    // kk counts negedges since enable was raised; inputs change and outputs
    // are sampled there, half a period away from the active edge.
    task automatic nstep();
        @(negedge clk_tmds);
        kk++;
    endtask

    task automatic pstep();
        nstep();
        if (kk % 10 == ph) pix_toggle = ~pix_toggle;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pix_toggle = 1'b0;
        word_red = '0; word_green = '0; word_blue = '0;
        kk = 0; ph = 8;
        ctrl_w = TMDS_CTRL_00;
        clk_w  = TMDS_CLK_PATTERN;
        repeat (3) @(negedge clk_tmds);
        n_cmp++;
        if ({ser_red, ser_green, ser_blue, ser_clk, load, locked} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 000000",
                {ser_red, ser_green, ser_blue, ser_clk, load, locked});
        end
        n_cmp++;
        if (slip_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_slip: got %0d expected 0", slip_count);
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk_tmds);
        n_cmp++;
        if (dbg_state !== IDLE || load !== 1'b0 || ser_clk !== 1'b0) begin
            n_bad++; $display("FAIL idle_disabled: got state %0d load %b ser_clk %b expected 0 0 0",
                dbg_state, load, ser_clk);
        end
    endtask

    task automatic test_lock(input logic [7:0] exp_slip);
        logic exp_load;
        logic exp_locked;
        int b;
        word_red = 10'h3FF; word_green = 10'h155; word_blue = 10'h2AA;
        @(negedge clk_tmds);
        enable = 1'b1; kk = 0; ph = 8;
        for (int i = 0; i < 165; i++) begin
            pstep();
            exp_load   = ((kk - 1) % 10 == 4);
            exp_locked = (kk >= 161);
            n_cmp++;
            if (load !== exp_load) begin
                n_bad++; $display("FAIL lock_load k=%0d: got %b expected %b", kk, load, exp_load);
            end
            n_cmp++;
            if (locked !== exp_locked) begin
                n_bad++; $display("FAIL lock_locked k=%0d: got %b expected %b", kk, locked, exp_locked);
            end
            if (kk <= 5) begin
                n_cmp++;
                if ({ser_red, ser_green, ser_blue, ser_clk} !== 4'b0) begin
                    n_bad++; $display("FAIL search_pre_load k=%0d: got %b expected 0000", kk,
                        {ser_red, ser_green, ser_blue, ser_clk});
                end
            end
            if (kk >= 6 && kk <= 15) begin
                b = kk - 6;
                n_cmp++;
                if ({ser_red, ser_green, ser_blue} !== {3{ctrl_w[b]}}) begin
                    n_bad++; $display("FAIL search_ctrl bit%0d: got %b expected %b", b,
                        {ser_red, ser_green, ser_blue}, {3{ctrl_w[b]}});
                end
                n_cmp++;
                if (ser_clk !== clk_w[b]) begin
                    n_bad++; $display("FAIL search_clk bit%0d: got %b expected %b", b, ser_clk, clk_w[b]);
                end
            end
        end
        n_cmp++;
        if (slip_count !== exp_slip) begin
            n_bad++; $display("FAIL lock_slip: got %0d expected %0d", slip_count, exp_slip);
        end
        n_cmp++;
        if (dbg_state !== LOCKED) begin
            n_bad++; $display("FAIL lock_state: got %0d expected %0d", dbg_state, LOCKED);
        end
    endtask

    task automatic test_data_locked();
        logic [9:0] wr, wg, wb;
        wr = 10'b1010011100; wg = 10'b0111110000; wb = 10'b1000000001;
        pstep();
        word_red = wr; word_green = wg; word_blue = wb;
        while (kk % 10 != 5) pstep();
        n_cmp++;
        if (load !== 1'b1) begin
            n_bad++; $display("FAIL data_load: got %b expected 1", load);
        end
        for (int b = 0; b < 10; b++) begin
            pstep();
            n_cmp++;
            if ({ser_red, ser_green, ser_blue, ser_clk} !== {wr[b], wg[b], wb[b], clk_w[b]}) begin
                n_bad++; $display("FAIL data_bit%0d: got %b expected %b", b,
                    {ser_red, ser_green, ser_blue, ser_clk}, {wr[b], wg[b], wb[b], clk_w[b]});
            end
        end
    endtask

    task automatic test_enable_mid_word();
        pstep();
        pstep();
        nstep();
        n_cmp++;
        if (ser_red !== 1'b1 || ser_clk !== 1'b1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL mid_word_before: got red %b clk %b locked %b expected 1 1 1",
                ser_red, ser_clk, locked);
        end
        enable = 1'b0;
        nstep();
        n_cmp++;
        if ({ser_red, ser_green, ser_blue, ser_clk, load, locked} !== 6'b0) begin
            n_bad++; $display("FAIL disable_clear: got %b expected 000000",
                {ser_red, ser_green, ser_blue, ser_clk, load, locked});
        end
        n_cmp++;
        if (dbg_state !== IDLE || slip_count !== 8'd0) begin
            n_bad++; $display("FAIL disable_state: got state %0d slip %0d expected %0d 0",
                dbg_state, slip_count, IDLE);
        end
        repeat (4) nstep();
        n_cmp++;
        if (dbg_state !== IDLE || ser_clk !== 1'b0) begin
            n_bad++; $display("FAIL disable_hold: got state %0d ser_clk %b expected %0d 0",
                dbg_state, ser_clk, IDLE);
        end
    endtask

    // Shared relock tracking after a disturbance at negedge k0.
    task automatic track_relock(input int k0, input logic [7:0] exp_slip, input string tag);
        logic exp_locked;
        while (kk < k0 + 163) begin
            pstep();
            exp_locked = (kk <= k0 + 2) || (kk >= k0 + 163);
            n_cmp++;
            if (locked !== exp_locked) begin
                n_bad++; $display("FAIL %s_locked k=%0d: got %b expected %b", tag, kk - k0, locked, exp_locked);
            end
            if (kk == k0 + 3) begin
                n_cmp++;
                if (slip_count !== exp_slip) begin
                    n_bad++; $display("FAIL %s_slip: got %0d expected %0d", tag, slip_count, exp_slip);
                end
            end
        end
        n_cmp++;
        if (dbg_state !== LOCKED || slip_count !== exp_slip) begin
            n_bad++; $display("FAIL %s_relock: got state %0d slip %0d expected %0d %0d",
                tag, dbg_state, slip_count, LOCKED, exp_slip);
        end
    endtask

    task automatic test_drop_relock();
        int k0;
        while (kk % 10 != 7) pstep();
        nstep();
        k0 = kk;
        track_relock(k0, 8'd1, "drop");
    endtask

    task automatic test_shift_relock();
        int k0;
        while (kk % 10 != 4) pstep();
        ph = 5;
        pstep();
        k0 = kk;
        track_relock(k0, 8'd2, "shift");
    endtask

    task automatic test_slip_saturate();
        for (int j = 1; j <= 300; j++) begin
            nstep();
            pix_toggle = ~pix_toggle;
            if (j == 50) begin
                n_cmp++;
                if (slip_count !== 8'd49 || locked !== 1'b0) begin
                    n_bad++; $display("FAIL slip_burst50: got %0d locked %b expected 49 0", slip_count, locked);
                end
            end
            if (j == 255) begin
                n_cmp++;
                if (slip_count !== 8'd254) begin
                    n_bad++; $display("FAIL slip_burst255: got %0d expected 254", slip_count);
                end
            end
            if (j == 300) begin
                n_cmp++;
                if (slip_count !== 8'd255) begin
                    n_bad++; $display("FAIL slip_saturate: got %0d expected 255", slip_count);
                end
            end
        end
        repeat (5) nstep();
        n_cmp++;
        if (slip_count !== 8'd255) begin
            n_bad++; $display("FAIL slip_hold: got %0d expected 255", slip_count);
        end
    endtask

    task automatic test_reset_mid_word();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            nstep();
            if (load === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL reset_wait_load: got no load in 20 cycles expected one");
        end
        nstep();
        n_cmp++;
        if (ser_clk !== clk_w[0] || ser_red !== ctrl_w[0]) begin
            n_bad++; $display("FAIL reset_pre: got clk %b red %b expected %b %b",
                ser_clk, ser_red, clk_w[0], ctrl_w[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ser_red, ser_green, ser_blue, ser_clk, load, locked} !== 6'b0 || slip_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_mid_word: got %b slip %0d expected 000000 0",
                {ser_red, ser_green, ser_blue, ser_clk, load, locked}, slip_count);
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_bad++; $display("FAIL reset_mid_state: got %0d expected %0d", dbg_state, IDLE);
        end
        repeat (2) @(negedge clk_tmds);
        rst_n = 1'b1;
        enable = 1'b0;
        @(negedge clk_tmds);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock(8'd0);
        test_data_locked();
        test_enable_mid_word();
        test_lock(8'd0);
        test_drop_relock();
        test_shift_relock();
        test_slip_saturate();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
